i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
I2C target (slave) for the other end of the bus driven by our I2C master. It synchronises raw SCL/SDA, detects START, repeated START and STOP, matches a 7-bit address, and serves a byte-addressed register file. Writes use register-pointer-then-data framing with pointer auto-increment. Reads return bytes from the current pointer. A host-side port gives the local system read/write access to the same register file.

Parameters:
SLAVE_ADDR, 7'h55, 7-bit bus address; matches write byte 8'hAA and read byte 8'hAB.
NUM_REGS, 16, number of 8-bit registers; pointer wraps modulo NUM_REGS; power of two, 2..256.

Ports:
clk  in  1  system clock; must be at least 8x the SCL frequency.
rst  in  1  synchronous, active-high reset.
scl_i  in  1  raw SCL pin level (asynchronous).
sda_i  in  1  raw SDA pin level (asynchronous).
sda_oe  out  1  1 = pull SDA low; 0 = release (open drain).
host_we  in  1  host write strobe, one cycle.
host_addr  in  $clog2(NUM_REGS)  host register index.
host_wdata  in  8  host write data.
host_rdata  out  8  regs[host_addr], combinational read.
wr_pulse  out  1  one-cycle pulse when a bus data byte is committed.
busy  out  1  1 from an addressed START up to STOP or NACK release.

Behaviour:
- Reset: sda_oe=0, busy=0, wr_pulse=0, pointer=0, all regs=0, state=IDLE. Both synchronisers reset to 1.
- Input path: 2-flop synchroniser per line, plus one history flop for edge detection. Internal events lag the pins by 3 clk.
- START (incl. repeated): synced SDA 1->0 while SCL=1. Enter ADDR from any state, clear bit counter, sda_oe=0.
- STOP: synced SDA 0->1 while SCL=1. Enter IDLE from any state, sda_oe=0, busy=0.
- START/STOP have priority over a same-cycle SCL edge.
- Bit timing: sample SDA on synced SCL rising edge, MSB first. Change sda_oe only on synced SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- ADDR: after 8 bits, if byte[7:1]==SLAVE_ADDR, go to ADDR_ACK and set busy=1. Otherwise go to IDLE and never drive the bus.
- ADDR_ACK: on the falling edge after bit 8, sda_oe=1. On the next falling edge:
  - R/W=0: release SDA, go to PTR.
  - R/W=1: drive bit 7 of regs[pointer], go to RDATA.
- PTR: 8 bits load pointer (low $clog2(NUM_REGS) bits), then PTR_ACK (ACK like ADDR_ACK), then WDATA.
- WDATA: after 8 bits, regs[pointer]<=byte, wr_pulse=1 for one cycle, pointer<=pointer+1 mod NUM_REGS. Go to WDATA_ACK (always ACK), then WDATA again.
- RDATA: sda_oe = ~bit. Shift register is loaded at the transition into RDATA. After the 8th falling edge, release SDA and go to RACK.
- RACK: sample master ACK on the rising edge; pointer<=pointer+1.
  - SDA=0 (ACK): at the falling edge, load the next byte and continue RDATA.
  - SDA=1 (NACK): go to IDLE-wait with sda_oe=0 until STOP/START; busy=0.
- Pointer persists across transactions. A read after a write-with-pointer-only (repeated START) reads from the written pointer.
- Host write and bus write to the same register in the same cycle: bus wins. Host writes to other indices proceed.
- rst mid-transaction: everything returns to reset values next cycle; SDA is released immediately.
- A byte ended by START/STOP before 8 bits is discarded: no reg write, no pointer change.

Test Plan:
- Write 0xAA, 0x03, 0x11, 0x22, STOP -> ACK on all 4 bytes; regs[3]=0x11, regs[4]=0x22; two wr_pulse; busy 1->0 at STOP.
- Write 0xAA,0x03; repeated START; 0xAB; master ACK, then NACK -> bus sees 0x11, 0x22; pointer=5; sda_oe=0 after NACK.
- Address 0xA8 (mismatch) followed by data bytes -> sda_oe stays 0 throughout; busy=0; regs unchanged.
- Pointer 0x0F, write 0x5A, 0x6B -> regs[15]=0x5A, regs[0]=0x6B (wrap at NUM_REGS=16).
- host_we to index 7 with 0x99, then bus read at pointer 7 -> 0x99 on SDA. Same-cycle host/bus write to index 2 -> bus value kept.
- Assert rst while driving a read bit low, or send STOP after 4 data bits -> sda_oe=0 next cycle; no reg change; a subsequent transaction works.

Source files
------------

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with pointer-addressed register file and host-side access port
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int          NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  input  logic                        host_we,
  input  logic [$clog2(NUM_REGS)-1:0] host_addr,
  input  logic [7:0]                  host_wdata,
  output logic [7:0]                  host_rdata,
  output logic                        wr_pulse,
  output logic                        busy
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_scl_m, r_scl_s, r_scl_d;
  logic          r_sda_m, r_sda_s, r_sda_d;
  logic [7:0]    r_regs [NUM_REGS];
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic [6:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic          r_sda_oe, w_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_rw, w_rw_nxt;
  logic          r_wr_pulse, w_wr_en;
  logic          w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]    w_byte, w_rd_byte;

  assign w_scl_rise = r_scl_s & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s & r_scl_d;
  assign w_start    = r_scl_s & r_sda_d & ~r_sda_s;
  assign w_stop     = r_scl_s & ~r_sda_d & r_sda_s;
  assign w_byte     = {r_shift, r_sda_s};
  assign w_rd_byte  = r_regs[r_ptr];

  assign host_rdata = r_regs[host_addr];
  // Release SDA in the same cycle rst rises, not one cycle later.
  assign sda_oe     = r_sda_oe & ~rst;
  assign busy       = r_busy;
  assign wr_pulse   = r_wr_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_scl_m, r_scl_s, r_scl_d} <= 3'b111;
      {r_sda_m, r_sda_s, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_m, r_scl_s, r_scl_d} <= {scl_i, r_scl_m, r_scl_s};
      {r_sda_m, r_sda_s, r_sda_d} <= {sda_i, r_sda_m, r_sda_s};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_oe_nxt    = r_sda_oe;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_ptr_nxt   = r_ptr;
    w_rw_nxt    = r_rw;
    w_wr_en     = 1'b0;
    if (w_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = 3'd0;
      w_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              case (r_state)
                S_ADDR: begin
                  if (w_byte[7:1] == SLAVE_ADDR) begin
                    w_state_nxt = S_ADDR_ACK;
                    w_busy_nxt  = 1'b1;
                    w_rw_nxt    = w_byte[0];
                  end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                  end
                end
                S_PTR: begin
                  w_ptr_nxt   = w_byte[AW-1:0];
                  w_state_nxt = S_PTR_ACK;
                end
                default: begin
                  w_wr_en     = 1'b1;
                  w_ptr_nxt   = r_ptr + AW'(1);
                  w_state_nxt = S_WDATA_ACK;
                end
              endcase
            end
          end
        end
        // First falling edge pulls SDA for the ACK slot; the second ends it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 3'd0;
            if (!r_sda_oe) begin
              w_oe_nxt = 1'b1;
            end else if (r_state == S_ADDR_ACK && r_rw) begin
              w_shift_nxt = w_rd_byte[6:0];
              w_oe_nxt    = ~w_rd_byte[7];
              w_state_nxt = S_RDATA;
            end else begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_RACK;
            end else begin
              w_oe_nxt    = ~r_shift[6];
              w_shift_nxt = {r_shift[5:0], 1'b0};
              w_cnt_nxt   = r_cnt + 3'd1;
            end
          end
        end
        S_RACK: begin
          if (w_scl_rise) begin
            w_ptr_nxt = r_ptr + AW'(1);
            if (r_sda_s) begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall) begin
            w_shift_nxt = w_rd_byte[6:0];
            w_oe_nxt    = ~w_rd_byte[7];
            w_cnt_nxt   = 3'd0;
            w_state_nxt = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= 3'd0;
      r_shift    <= 7'd0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_wr_pulse <= 1'b0;
    end else begin
      r_sda_oe   <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rw       <= w_rw_nxt;
      r_wr_pulse <= w_wr_en;
    end
  end

  // Bus commit is issued after the host write so it wins on the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'd0;
    end else begin
      if (host_we) r_regs[host_addr] <= host_wdata;
      if (w_wr_en) r_regs[r_ptr] <= w_byte;
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - randomized I2C master driver with bus-level scoreboard for i2c_slave
module tb_i2c_slave;
  localparam int Q  = 6;
  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] host_wdata = 8'd0;
  logic       sda_oe, wr_pulse, busy;
  logic [7:0] host_rdata;
  logic       line_sda;

  assign line_sda = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h55), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(line_sda), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_pulse(wr_pulse), .busy(busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       a;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_regs [NR];
  int         m_ptr = 0;
  int         exp_wr = 0;
  int         wr_seen = 0;
  logic       oe_seen = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bus monitor: decodes 9-clock frames from the wired-AND line and pops expectations.
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         mbits = 0;
  logic [8:0] mshift = 9'd0;
  always @(negedge clk) begin
    exp_t e;
    if (wr_pulse) wr_seen++;
    if (sda_oe) oe_seen = 1'b1;
    if (m_scl && p_scl && (line_sda != p_sda)) begin
      mbits = 0;
    end else if (m_scl && !p_scl) begin
      mshift = {mshift[7:0], line_sda};
      mbits++;
      if (mbits == 9) begin
        mbits = 0;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_frame actual=%0h required=none", mshift);
        end else begin
          e = sbq.pop_front();
          chk("sb_byte", {24'd0, mshift[8:1]}, {24'd0, e.d});
          chk("sb_ack", {31'd0, mshift[0]}, {31'd0, e.a});
        end
      end
    end
    p_scl = m_scl;
    p_sda = line_sda;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(logic b, logic collide, logic [7:0] cval);
    m_sda = b;
    tick(Q);
    m_scl = 1'b1;
    if (collide) begin
      // host_we lands on the same edge as the bus commit (3 clk synchroniser lag).
      tick(2);
      host_addr  = 4'd2;
      host_wdata = cval;
      host_we    = 1'b1;
      tick(1);
      host_we    = 1'b0;
      tick(2 * Q - 3);
    end else begin
      tick(2 * Q);
    end
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic bit_in(output logic b);
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    b = line_sda;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask

  task automatic write_byte(logic [7:0] d, logic exp_ack, logic collide, logic [7:0] cval);
    logic b;
    sbq.push_back('{d: d, a: exp_ack});
    for (int i = 7; i >= 0; i--) bit_out(d[i], collide && (i == 0), cval);
    bit_in(b);
  endtask

  task automatic read_byte(logic [7:0] exp_d, logic mack);
    logic b;
    sbq.push_back('{d: exp_d, a: mack});
    for (int i = 0; i < 8; i++) bit_in(b);
    bit_out(mack, 1'b0, 8'd0);
  endtask

  task automatic bus_write(int p, int n, logic [7:0] d0, logic [7:0] d1, bit rnd);
    logic [7:0] d;
    logic [7:0] pb;
    pb = p[7:0];
    i2c_start();
    write_byte(8'hAA, 1'b0, 1'b0, 8'd0);
    chk("busy_addressed", {31'd0, busy}, 32'd1);
    write_byte(pb, 1'b0, 1'b0, 8'd0);
    m_ptr = p % NR;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : ((i == 0) ? d0 : d1);
      write_byte(d, 1'b0, 1'b0, 8'd0);
      m_regs[m_ptr] = d;
      m_ptr = (m_ptr + 1) % NR;
      exp_wr++;
    end
    i2c_stop();
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    chk("wr_pulse_count", wr_seen, exp_wr);
  endtask

  task automatic bus_read(bit set_ptr, int p, int n);
    logic [7:0] pb;
    pb = p[7:0];
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hAA, 1'b0, 1'b0, 8'd0);
      write_byte(pb, 1'b0, 1'b0, 8'd0);
      m_ptr = p % NR;
      i2c_start();
    end
    write_byte(8'hAB, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(m_regs[m_ptr], (i == n - 1));
      m_ptr = (m_ptr + 1) % NR;
    end
    chk("nack_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("nack_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
  endtask

  task automatic host_write(int idx, logic [7:0] d);
    host_addr  = idx[3:0];
    host_wdata = d;
    host_we    = 1'b1;
    tick(1);
    host_we    = 1'b0;
    m_regs[idx] = d;
  endtask

  task automatic host_rd_chk(string name, int idx, logic [7:0] req);
    host_addr = idx[3:0];
    #1;
    chk(name, {24'd0, host_rdata}, {24'd0, req});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       b;
    int         k;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'd0;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    host_rd_chk("reset_reg0", 0, 8'h00);

    bus_write(3, 2, 8'h11, 8'h22, 1'b0);
    host_rd_chk("wr_reg3", 3, 8'h11);
    host_rd_chk("wr_reg4", 4, 8'h22);

    bus_read(1'b1, 3, 2);
    bus_read(1'b0, 0, 1);

    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA8, 1'b1, 1'b0, 8'd0);
    chk("mismatch_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h5C, 1'b1, 1'b0, 8'd0);
    write_byte(8'hC3, 1'b1, 1'b0, 8'd0);
    i2c_stop();
    chk("mismatch_oe_seen", {31'd0, oe_seen}, 32'd0);
    chk("mismatch_wr_count", wr_seen, exp_wr);

    bus_write(8'h0F, 2, 8'h5A, 8'h6B, 1'b0);
    host_rd_chk("wrap_reg15", 15, 8'h5A);
    host_rd_chk("wrap_reg0", 0, 8'h6B);

    host_write(7, 8'h99);
    bus_read(1'b1, 7, 1);

    d = 8'($urandom);
    i2c_start();
    write_byte(8'hAA, 1'b0, 1'b0, 8'd0);
    write_byte(8'h02, 1'b0, 1'b0, 8'd0);
    write_byte(d, 1'b0, 1'b1, ~d);
    m_regs[2] = d;
    m_ptr = 3;
    exp_wr++;
    i2c_stop();
    host_rd_chk("collide_reg2", 2, d);

    host_write(9, 8'h35);
    bus_write(9, 0, 8'd0, 8'd0, 1'b0);
    i2c_start();
    write_byte(8'hAB, 1'b0, 1'b0, 8'd0);
    k = 0;
    while (!sda_oe && k < 20) begin
      tick(1);
      k++;
    end
    chk("rst_wait_oe", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_sda_release", {31'd0, sda_oe}, 32'd0);
    tick(1);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < NR; i++) m_regs[i] = 8'd0;
    m_ptr = 0;
    host_rd_chk("rst_reg9", 9, 8'h00);
    i2c_stop();

    host_write(6, 8'h4E);
    i2c_start();
    write_byte(8'hAA, 1'b0, 1'b0, 8'd0);
    write_byte(8'h06, 1'b0, 1'b0, 8'd0);
    m_ptr = 6;
    for (int i = 0; i < 4; i++) bit_out(1'($urandom), 1'b0, 8'd0);
    i2c_stop();
    chk("partial_sda_oe", {31'd0, sda_oe}, 32'd0);
    host_rd_chk("partial_reg6", 6, 8'h4E);
    chk("partial_wr_count", wr_seen, exp_wr);

    bus_write($urandom_range(0, 255), 2, 8'd0, 8'd0, 1'b1);
    bus_read(1'b0, 0, 1);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0: bus_write($urandom_range(0, 255), $urandom_range(1, 4), 8'd0, 8'd0, 1'b1);
        1: bus_read(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(1, 4));
        default: host_write($urandom_range(0, NR - 1), 8'($urandom));
      endcase
    end

    for (int i = 0; i < NR; i++) host_rd_chk("final_reg", i, m_regs[i]);
    chk("final_wr_count", wr_seen, exp_wr);
    chk("final_sb_empty", sbq.size(), 0);
    b = busy;
    chk("final_busy", {31'd0, b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
